// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 master/slave pair.
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  localparam int SPI_WORD_W = 8;
  localparam logic [SPI_WORD_W-1:0] SPI_FILL_DEFAULT = 8'h00;

endpackage

// File: rtl/spi_mode0_slave_if.sv
// SPI wire side plus byte-level tx/rx handshake of the mode-0 slave.
// Optional build macro: SPI_SLAVE_FRAME_ERR_EN adds frame_err.
interface spi_mode0_slave_if;
  import spi_pkg::*;

  logic                  sclk;
  logic                  ss;
  logic                  mosi;
  logic                  miso;
  logic [SPI_WORD_W-1:0] tx_data;
  logic                  tx_load;
  logic                  tx_ready;
  logic [SPI_WORD_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  tx_underrun;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic                  frame_err;
`endif

  modport slave (
    input  sclk, ss, mosi, tx_data, tx_load,
    output miso, tx_ready, rx_data, rx_valid, busy, tx_underrun
`ifdef SPI_SLAVE_FRAME_ERR_EN
    , output frame_err
`endif
  );

  modport master (
    output sclk, ss, mosi, tx_data, tx_load,
    input  miso, tx_ready, rx_data, rx_valid, busy, tx_underrun
`ifdef SPI_SLAVE_FRAME_ERR_EN
    , input frame_err
`endif
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an async input with registered-history edge pulses.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_mode0_slave.sv
// SPI mode-0 target: oversampled sclk/ss/mosi, MSB-first bytes, one-byte tx buffer.
// Optional build macro: SPI_SLAVE_FRAME_ERR_EN (frame_err pulse on aborted partial byte).
module spi_mode0_slave
  import spi_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [SPI_WORD_W-1:0] FILL_BYTE   = SPI_FILL_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  spi_mode0_slave_if.slave    bus
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .d_i(bus.sclk),
    .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .d_i(bus.ss),
    .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_sync_q <= '0;
    else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_state_e            state_q;
  logic [2:0]            bit_cnt_q;
  logic [SPI_WORD_W-1:0] shift_in_q;
  logic [SPI_WORD_W-1:0] shift_out_q;
  logic [SPI_WORD_W-1:0] buf_q;
  logic [SPI_WORD_W-1:0] rx_data_q;
  logic                  miso_q;
  logic                  tx_ready_q;
  logic                  rx_valid_q;
  logic                  tx_underrun_q;
  logic                  byte_done_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic                  bit_seen_q;
  logic                  frame_err_q;
`endif

  logic                  load_ok;
  logic                  consume;
  logic [SPI_WORD_W-1:0] next_byte;

  assign load_ok   = bus.tx_load & tx_ready_q;
  assign next_byte = tx_ready_q ? FILL_BYTE : buf_q;
  // A frame only starts with sclk at its mode-0 idle level; ss rise beats a same-cycle sclk fall.
  assign consume   = ((state_q == ST_IDLE) && ss_fall && !sclk_s) ||
                     ((state_q == ST_ACTIVE) && !ss_rise && sclk_fall && byte_done_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= 3'd7;
      shift_in_q    <= '0;
      shift_out_q   <= '0;
      buf_q         <= '0;
      rx_data_q     <= '0;
      miso_q        <= 1'b0;
      tx_ready_q    <= 1'b1;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      byte_done_q   <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      bit_seen_q    <= 1'b0;
      frame_err_q   <= 1'b0;
`endif
    end else begin
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q   <= 1'b0;
`endif
      if (load_ok) begin
        buf_q      <= bus.tx_data;
        tx_ready_q <= 1'b0;
      end
      // A byte loaded in the consuming cycle stays in the buffer for the next byte.
      if (consume) begin
        shift_out_q   <= next_byte;
        miso_q        <= next_byte[SPI_WORD_W-1];
        tx_underrun_q <= tx_ready_q;
        if (!load_ok) tx_ready_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (consume) begin
            state_q     <= ST_ACTIVE;
            bit_cnt_q   <= 3'd7;
            shift_in_q  <= '0;
            byte_done_q <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            bit_seen_q  <= 1'b0;
`endif
          end
        end
        ST_ACTIVE: begin
          if (ss_rise) begin
            state_q     <= ST_IDLE;
            miso_q      <= 1'b0;
            bit_cnt_q   <= 3'd7;
            shift_in_q  <= '0;
            byte_done_q <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q <= bit_seen_q & ~byte_done_q;
            bit_seen_q  <= 1'b0;
`endif
          end else if (sclk_rise) begin
            shift_in_q <= {shift_in_q[SPI_WORD_W-2:0], mosi_s};
`ifdef SPI_SLAVE_FRAME_ERR_EN
            bit_seen_q <= 1'b1;
`endif
            if (bit_cnt_q == 3'd0) begin
              rx_data_q   <= {shift_in_q[SPI_WORD_W-2:0], mosi_s};
              rx_valid_q  <= 1'b1;
              byte_done_q <= 1'b1;
            end
          end else if (sclk_fall) begin
            if (byte_done_q) begin
              bit_cnt_q   <= 3'd7;
              byte_done_q <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
              bit_seen_q  <= 1'b0;
`endif
            end else if (bit_cnt_q != 3'd0) begin
              bit_cnt_q   <= bit_cnt_q - 3'd1;
              shift_out_q <= {shift_out_q[SPI_WORD_W-2:0], 1'b0};
              miso_q      <= shift_out_q[SPI_WORD_W-2];
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.miso        = miso_q;
  assign bus.tx_ready    = tx_ready_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.busy        = ~ss_s;
  assign bus.tx_underrun = tx_underrun_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  assign bus.frame_err   = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_mode0_slave.sv
// Directed bench for spi_mode0_slave: bench plays the mode-0 master.
// Optional build macro: SPI_SLAVE_FRAME_ERR_EN enables the frame_err checks.
module tb_spi_mode0_slave;

  localparam int H = 8;  // clk cycles per sclk half period

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  spi_mode0_slave_if bus();

  spi_mode0_slave #(.SYNC_STAGES(2), .FILL_BYTE(8'h00)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int         rx_cnt = 0;
  int         udr_cnt = 0;
  int         ferr_cnt = 0;
  logic [7:0] rx_log [0:63];

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rx_log[rx_cnt % 64] = bus.rx_data;
      rx_cnt++;
    end
    if (bus.tx_underrun) udr_cnt++;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    if (bus.frame_err) ferr_cnt++;
`endif
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
    wclk(1);
  endtask

  task automatic start_frame();
    @(negedge clk);
    bus.ss = 1'b0;
    wclk(H);
  endtask

  // Shifts nbits MSB-first; with last set the final sclk fall coincides with ss rise.
  task automatic xfer(input logic [7:0] mo, input int nbits, input logic last, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = mo[7-i];
      wclk(H);
      mi[7-i] = bus.miso;
      bus.sclk = 1'b1;
      wclk(H);
      bus.sclk = 1'b0;
      if (last && i == nbits - 1) bus.ss = 1'b1;
    end
    bus.mosi = 1'b0;
    wclk(2);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_miso"},     {7'd0, bus.miso}, 8'h00);
    chk({tag, "_tx_ready"}, {7'd0, bus.tx_ready}, 8'h01);
    chk({tag, "_rx_data"},  bus.rx_data, 8'h00);
    chk({tag, "_rx_valid"}, {7'd0, bus.rx_valid}, 8'h00);
    chk({tag, "_busy"},     {7'd0, bus.busy}, 8'h00);
    chk({tag, "_underrun"}, {7'd0, bus.tx_underrun}, 8'h00);
  endtask

  initial begin
    logic [7:0] mi, mi2;
    int rx0, udr0, ferr0;

    rst = 1'b1;
    bus.sclk = 1'b0; bus.ss = 1'b1; bus.mosi = 1'b0;
    bus.tx_data = 8'h00; bus.tx_load = 1'b0;
    wclk(4);
    chk_reset_vals("rst");
    rst = 1'b0;
    wclk(4);

    // 1 + 6: preload A5, second load while full is ignored, master sends 3C
    load(8'hA5);
    chk("t1_ready_after_load", {7'd0, bus.tx_ready}, 8'h00);
    load(8'h5F);
    chk("t6_ready_still_low", {7'd0, bus.tx_ready}, 8'h00);
    rx0 = rx_cnt; udr0 = udr_cnt;
    start_frame();
    chk("t1_busy_mid", {7'd0, bus.busy}, 8'h01);
    chk("t1_ready_after_consume", {7'd0, bus.tx_ready}, 8'h01);
    xfer(8'h3C, 8, 1'b1, mi);
    wclk(H);
    chk("t1_miso_byte", mi, 8'hA5);
    chk("t1_rx_data", bus.rx_data, 8'h3C);
    chk("t1_rx_pulses", 8'(rx_cnt - rx0), 8'd1);
    chk("t1_underruns", 8'(udr_cnt - udr0), 8'd0);
    chk("t1_busy_end", {7'd0, bus.busy}, 8'h00);
    chk("t1_miso_end", {7'd0, bus.miso}, 8'h00);

    // 2: empty buffer, fill byte goes out
    rx0 = rx_cnt; udr0 = udr_cnt;
    start_frame();
    xfer(8'hFF, 8, 1'b1, mi);
    wclk(H);
    chk("t2_miso_byte", mi, 8'h00);
    chk("t2_underruns", 8'(udr_cnt - udr0), 8'd1);
    chk("t2_rx_data", bus.rx_data, 8'hFF);
    chk("t2_rx_pulses", 8'(rx_cnt - rx0), 8'd1);

    // 3: two-byte burst, second byte loaded during the first
    load(8'h11);
    rx0 = rx_cnt; udr0 = udr_cnt;
    start_frame();
    chk("t3_ready_after_consume", {7'd0, bus.tx_ready}, 8'h01);
    load(8'h22);
    chk("t3_ready_after_load", {7'd0, bus.tx_ready}, 8'h00);
    xfer(8'h81, 8, 1'b0, mi);
    xfer(8'h7E, 8, 1'b1, mi2);
    wclk(H);
    chk("t3_miso_byte0", mi, 8'h11);
    chk("t3_miso_byte1", mi2, 8'h22);
    chk("t3_rx_pulses", 8'(rx_cnt - rx0), 8'd2);
    chk("t3_rx_first", rx_log[rx0 % 64], 8'h81);
    chk("t3_rx_second", rx_log[(rx0 + 1) % 64], 8'h7E);
    chk("t3_underruns", 8'(udr_cnt - udr0), 8'd0);
    chk("t3_ready_end", {7'd0, bus.tx_ready}, 8'h01);

    // 4: ss rises after 3 bits
    rx0 = rx_cnt; ferr0 = ferr_cnt;
    start_frame();
    xfer(8'hE0, 3, 1'b1, mi);
    wclk(H);
    chk("t4_rx_pulses", 8'(rx_cnt - rx0), 8'd0);
    chk("t4_busy", {7'd0, bus.busy}, 8'h00);
    chk("t4_miso", {7'd0, bus.miso}, 8'h00);
    chk("t4_rx_data_held", bus.rx_data, 8'h7E);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    chk("t4_frame_err", 8'(ferr_cnt - ferr0), 8'd1);
`endif

    // 5: reset in the middle of bit 5, then a clean 5A transfer
    load(8'hC3);
    rx0 = rx_cnt;
    start_frame();
    xfer(8'h5A, 4, 1'b0, mi);
    bus.mosi = 1'b1;
    wclk(H);
    bus.sclk = 1'b1;
    wclk(3);
    rst = 1'b1;
    #1;
    chk_reset_vals("t5_rst");
    chk("t5_no_partial", 8'(rx_cnt - rx0), 8'd0);
    @(negedge clk);
    bus.sclk = 1'b0; bus.ss = 1'b1; bus.mosi = 1'b0;
    wclk(4);
    rst = 1'b0;
    wclk(4);
    rx0 = rx_cnt;
    start_frame();
    xfer(8'h5A, 8, 1'b1, mi);
    wclk(H);
    chk("t5_rx_data", bus.rx_data, 8'h5A);
    chk("t5_rx_pulses", 8'(rx_cnt - rx0), 8'd1);
    chk("t5_miso_byte", mi, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
